// File: rtl/tile_window_gen_pkg.sv
// Shared definitions for the tile reader / window generator pipeline.
package tile_window_gen_pkg;

    // Window edge length of the convolution kernel.
    localparam int WIN_K = 3;

    // Stride encoding carried by cfg_stride2.
    typedef enum logic {
        STRIDE_1 = 1'b0,
        STRIDE_2 = 1'b1
    } stride_e;

    // Tile-level control states.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // Advance a row slot around the three-row circular buffer.
    function automatic logic [1:0] slotNext(input logic [1:0] slot);
        return (slot == 2'd2) ? 2'd0 : slot + 2'd1;
    endfunction

endpackage

// File: rtl/tile_window_gen_if.sv
// Pixel-in / window-out stream bundle of the window generator.
interface tile_window_gen_if #(
    parameter int DATA_W = 8,
    parameter int DIM_W  = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [9*DATA_W-1:0]   out_window;
    logic [DIM_W-1:0]      out_row;
    logic [DIM_W-1:0]      out_col;

    // Window generator side: consumes pixels, produces windows.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_window, out_row, out_col
    );

    // Upstream/downstream side: produces pixels, consumes windows.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_window, out_row, out_col
    );
endinterface

// File: rtl/tile_window_gen_line_buf3.sv
// Three-row circular line buffer: one write port, two same-column reads.
module line_buf3 #(
    parameter int DATA_W = 8,
    parameter int MAX_W  = 64,
    parameter int ADDR_W = (MAX_W > 1) ? $clog2(MAX_W) : 1
)(
    input  logic              clk,
    input  logic              i_wrEn,
    input  logic [1:0]        i_wrSlot,
    input  logic [ADDR_W-1:0] i_col,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic [1:0]        i_rdSlotA,
    input  logic [1:0]        i_rdSlotB,
    output logic [DATA_W-1:0] o_rdDataA,
    output logic [DATA_W-1:0] o_rdDataB
);

    logic [DATA_W-1:0] r_mem [0:2][0:MAX_W-1];

    // Row storage is intentionally unreset; every slot is written before it is read.
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            case (i_wrSlot)
                2'd0:    r_mem[0][i_col] <= i_wrData;
                2'd1:    r_mem[1][i_col] <= i_wrData;
                2'd2:    r_mem[2][i_col] <= i_wrData;
                default: ;
            endcase
        end
    end

    // Asynchronous reads return the old contents, ahead of a same-cycle write.
    always_comb begin
        case (i_rdSlotA)
            2'd1:    o_rdDataA = r_mem[1][i_col];
            2'd2:    o_rdDataA = r_mem[2][i_col];
            default: o_rdDataA = r_mem[0][i_col];
        endcase
        case (i_rdSlotB)
            2'd1:    o_rdDataB = r_mem[1][i_col];
            2'd2:    o_rdDataB = r_mem[2][i_col];
            default: o_rdDataB = r_mem[0][i_col];
        endcase
    end

endmodule

// File: rtl/tile_window_gen.sv
// Streaming 3x3 window generator for a raster-order zero-padded input tile.
module tile_window_gen
    import tile_window_gen_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIM_W  = 16,
    parameter int MAX_W  = 64
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_tile_in_h,
    input  logic [DIM_W-1:0] cfg_tile_in_w,
    input  logic             cfg_stride2,
    output logic             done,
    tile_window_gen_if.slave bus
);

    localparam int ADDR_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    state_e              r_state;
    stride_e             r_stride;
    logic [DIM_W-1:0]    r_inH;
    logic [DIM_W-1:0]    r_inW;
    logic [DIM_W-1:0]    r_row;
    logic [DIM_W-1:0]    r_col;
    logic [1:0]          r_slot;
    logic                r_rowEven;
    logic                r_colEven;
    logic                r_lastSeen;
    logic                r_outValid;
    logic [9*DATA_W-1:0] r_outWindow;
    logic [DIM_W-1:0]    r_outRow;
    logic [DIM_W-1:0]    r_outCol;
    logic                r_done;
    logic [DATA_W-1:0]   r_win [0:WIN_K-1][0:WIN_K-1];

    logic                w_inReady;
    logic                w_accept;
    logic                w_rowWrap;
    logic                w_isLast;
    logic                w_emit;
    logic [DIM_W-1:0]    w_rowOff;
    logic [DIM_W-1:0]    w_colOff;
    logic [DATA_W-1:0]   w_rdOld;
    logic [DATA_W-1:0]   w_rdMid;
    logic [DATA_W-1:0]   w_newCol [0:WIN_K-1];
    logic [9*DATA_W-1:0] w_newWindow;

    // Input is held off once the last pixel of the tile has been taken.
    assign w_inReady = (r_state == ST_ACTIVE) && !r_lastSeen && (!r_outValid || bus.out_ready);
    assign w_accept  = w_inReady && bus.in_valid;
    assign w_rowWrap = (r_col == r_inW - DIM_W'(1));
    assign w_isLast  = w_rowWrap && (r_row == r_inH - DIM_W'(1));
    assign w_emit    = w_accept && (r_row >= DIM_W'(2)) && (r_col >= DIM_W'(2)) &&
                       ((r_stride == STRIDE_1) || (r_rowEven && r_colEven));
    assign w_rowOff  = r_row - DIM_W'(2);
    assign w_colOff  = r_col - DIM_W'(2);

    // Row r-2 lives one slot ahead of the write slot, row r-1 two slots ahead.
    line_buf3 #(
        .DATA_W (DATA_W),
        .MAX_W  (MAX_W),
        .ADDR_W (ADDR_W)
    ) u_lineBuf (
        .clk       (clk),
        .i_wrEn    (w_accept),
        .i_wrSlot  (r_slot),
        .i_col     (r_col[ADDR_W-1:0]),
        .i_wrData  (bus.in_data),
        .i_rdSlotA (slotNext(r_slot)),
        .i_rdSlotB (slotNext(slotNext(r_slot))),
        .o_rdDataA (w_rdOld),
        .o_rdDataB (w_rdMid)
    );

    assign w_newCol[0] = w_rdOld;
    assign w_newCol[1] = w_rdMid;
    assign w_newCol[2] = bus.in_data;

    // Flattened view of the window as it will look after this cycle's shift.
    always_comb begin
        w_newWindow = '0;
        for (int i = 0; i < WIN_K; i++) begin
            for (int j = 0; j < WIN_K - 1; j++) begin
                w_newWindow[DATA_W*(WIN_K*i+j) +: DATA_W] = r_win[i][j+1];
            end
            w_newWindow[DATA_W*(WIN_K*i+WIN_K-1) +: DATA_W] = w_newCol[i];
        end
    end

    // Tile control: config latch, raster counters, phase toggles, shift register and output slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_stride    <= STRIDE_1;
            r_inH       <= '0;
            r_inW       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_slot      <= 2'd0;
            r_rowEven   <= 1'b1;
            r_colEven   <= 1'b1;
            r_lastSeen  <= 1'b0;
            r_outValid  <= 1'b0;
            r_outWindow <= '0;
            r_outRow    <= '0;
            r_outCol    <= '0;
            r_done      <= 1'b0;
            for (int i = 0; i < WIN_K; i++) begin
                for (int j = 0; j < WIN_K; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else if (start) begin
            r_state    <= ST_ACTIVE;
            r_stride   <= stride_e'(cfg_stride2);
            r_inH      <= cfg_tile_in_h;
            r_inW      <= cfg_tile_in_w;
            r_row      <= '0;
            r_col      <= '0;
            r_slot     <= 2'd0;
            r_rowEven  <= 1'b1;
            r_colEven  <= 1'b1;
            r_lastSeen <= 1'b0;
            r_outValid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: ;
                ST_ACTIVE: begin
                    if (r_lastSeen && !r_outValid) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        if (w_accept) begin
                            for (int i = 0; i < WIN_K; i++) begin
                                r_win[i][0] <= r_win[i][1];
                                r_win[i][1] <= r_win[i][2];
                                r_win[i][2] <= w_newCol[i];
                            end
                            if (w_rowWrap) begin
                                r_col     <= '0;
                                r_row     <= r_row + DIM_W'(1);
                                r_slot    <= slotNext(r_slot);
                                r_rowEven <= !r_rowEven;
                                r_colEven <= 1'b1;
                            end else begin
                                r_col     <= r_col + DIM_W'(1);
                                r_colEven <= !r_colEven;
                            end
                            if (w_isLast) begin
                                r_lastSeen <= 1'b1;
                            end
                        end
                        if (w_emit) begin
                            r_outValid  <= 1'b1;
                            r_outWindow <= w_newWindow;
                            r_outRow    <= (r_stride == STRIDE_2) ? (w_rowOff >> 1) : w_rowOff;
                            r_outCol    <= (r_stride == STRIDE_2) ? (w_colOff >> 1) : w_colOff;
                        end else if (bus.out_ready) begin
                            r_outValid <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Unsupported geometry is only flagged in simulation.
    assert property (@(posedge clk) disable iff (!rst_n)
        start |-> ((cfg_tile_in_w >= DIM_W'(3)) && (cfg_tile_in_w <= DIM_W'(MAX_W)) &&
                   (cfg_tile_in_h >= DIM_W'(3))));

    assign bus.in_ready   = w_inReady;
    assign bus.out_valid  = r_outValid;
    assign bus.out_window = r_outWindow;
    assign bus.out_row    = r_outRow;
    assign bus.out_col    = r_outCol;
    assign done           = r_done;

endmodule

// File: tb/tb_tile_window_gen.sv
// Scoreboard bench for tile_window_gen: ramp tiles, strides, stalls, abort and reset.
module tb_tile_window_gen;
    import tile_window_gen_pkg::*;

    localparam int DATA_W = 8;
    localparam int DIM_W  = 16;
    localparam int MAX_W  = 64;

    typedef struct packed {
        logic [DIM_W-1:0]    row;
        logic [DIM_W-1:0]    col;
        logic [9*DATA_W-1:0] win;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [DIM_W-1:0] cfg_tile_in_h = '0;
    logic [DIM_W-1:0] cfg_tile_in_w = '0;
    logic             cfg_stride2 = 1'b0;
    logic             done;

    tile_window_gen_if #(.DATA_W(DATA_W), .DIM_W(DIM_W)) bus ();

    tile_window_gen #(
        .DATA_W (DATA_W),
        .DIM_W  (DIM_W),
        .MAX_W  (MAX_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_tile_in_h (cfg_tile_in_h),
        .cfg_tile_in_w (cfg_tile_in_w),
        .cfg_stride2   (cfg_stride2),
        .done          (done),
        .bus           (bus.slave)
    );

    exp_t                sbQueue [$];
    int                  checks = 0;
    int                  failures = 0;
    int                  winCount = 0;
    int                  doneCount = 0;
    int                  acceptCount = 0;
    int                  cycleCount = 0;
    int                  lastAcceptCycle = 0;
    int                  doneCycle = 0;
    logic [9*DATA_W-1:0] firstWin = '0;
    logic [9*DATA_W-1:0] lastWin = '0;

    always #5 clk = ~clk;

    // Free-running cycle counter used for latency measurements.
    always @(posedge clk) cycleCount++;

    // Ramp pixel value at tile position (r,c).
    function automatic logic [DATA_W-1:0] pix(input int r, input int c, input int w);
        return DATA_W'((r * w + c) & 255);
    endfunction

    // Expected flattened window whose bottom-right pixel is (r,c).
    function automatic logic [9*DATA_W-1:0] expWin(input int r, input int c, input int w);
        logic [9*DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                v[DATA_W*(3*i+j) +: DATA_W] = pix(r - 2 + i, c - 2 + j, w);
            end
        end
        return v;
    endfunction

    // Pop and compare every window handshake; count done pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sbQueue.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_window: got row=%0d col=%0d win=%h, required no window",
                             bus.out_row, bus.out_col, bus.out_window);
                end else begin
                    exp_t e;
                    e = sbQueue.pop_front();
                    if (bus.out_window !== e.win || bus.out_row !== e.row || bus.out_col !== e.col) begin
                        failures++;
                        $display("[TB] FAIL window_data: got row=%0d col=%0d win=%h, required row=%0d col=%0d win=%h",
                                 bus.out_row, bus.out_col, bus.out_window, e.row, e.col, e.win);
                    end
                end
                if (winCount == 0) firstWin = bus.out_window;
                lastWin = bus.out_window;
                winCount++;
            end
            if (done === 1'b1) begin
                doneCount++;
                doneCycle = cycleCount;
            end
        end
    end

    // Stream one ramp tile, pushing expected windows as qualifying pixels are accepted.
    task automatic applyStimulus(input int h, input int w, input bit s2, input int maxPix,
                                 input int stallCycles, input bit waitDone);
        int idx;
        int budget;
        int total;
        int r;
        int c;
        int doneBefore;
        bit stalled;
        exp_t e;
        logic [9*DATA_W-1:0] held;
        total      = (maxPix < h * w) ? maxPix : h * w;
        idx        = 0;
        budget     = 0;
        stalled    = 1'b0;
        doneBefore = doneCount;
        @(posedge clk); #1;
        cfg_tile_in_h = DIM_W'(h);
        cfg_tile_in_w = DIM_W'(w);
        cfg_stride2   = s2;
        start         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = pix(0, 0, w);
        while (idx < total && budget < 2000) begin
            @(negedge clk);
            budget++;
            if (bus.in_valid && bus.in_ready) begin
                r = idx / w;
                c = idx % w;
                if (r >= 2 && c >= 2 && (!s2 || (((r - 2) % 2) == 0 && ((c - 2) % 2) == 0))) begin
                    e.row = DIM_W'((r - 2) >> s2);
                    e.col = DIM_W'((c - 2) >> s2);
                    e.win = expWin(r, c, w);
                    sbQueue.push_back(e);
                end
                lastAcceptCycle = cycleCount;
                acceptCount++;
                idx++;
            end
            @(posedge clk); #1;
            if (idx < total) bus.in_data = pix(idx / w, idx % w, w);
            else bus.in_valid = 1'b0;
            if (stallCycles > 0 && !stalled && bus.out_valid) begin
                stalled       = 1'b1;
                bus.out_ready = 1'b0;
                held          = bus.out_window;
                for (int k = 0; k < stallCycles; k++) begin
                    @(negedge clk);
                    checks++;
                    if (bus.in_ready !== 1'b0) begin
                        failures++;
                        $display("[TB] FAIL stall_in_ready: got %b, required 0 (stall cycle %0d)", bus.in_ready, k);
                    end
                    checks++;
                    if (bus.out_window !== held || bus.out_valid !== 1'b1) begin
                        failures++;
                        $display("[TB] FAIL stall_window: got valid=%b win=%h, required valid=1 win=%h",
                                 bus.out_valid, bus.out_window, held);
                    end
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        if (budget >= 2000) begin
            checks++;
            failures++;
            $display("[TB] FAIL stream_timeout: got %0d accepts, required %0d", idx, total);
        end
        if (waitDone) begin
            budget = 0;
            while (doneCount == doneBefore && budget < 100) begin
                @(posedge clk); #1;
                budget++;
            end
            checks++;
            if (doneCount == doneBefore) begin
                failures++;
                $display("[TB] FAIL done_timeout: got no done, required one within 100 cycles");
            end
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    task automatic clearStats();
        winCount    = 0;
        doneCount   = 0;
        acceptCount = 0;
        sbQueue.delete();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready: got %b, required 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
        checks++; if (bus.out_window !== '0) begin failures++; $display("[TB] FAIL reset_out_window: got %h, required 0", bus.out_window); end
        checks++; if (bus.out_row !== '0) begin failures++; $display("[TB] FAIL reset_out_row: got %0d, required 0", bus.out_row); end
        checks++; if (bus.out_col !== '0) begin failures++; $display("[TB] FAIL reset_out_col: got %0d, required 0", bus.out_col); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b, required 0", done); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL idle_in_ready: got %b, required 0", bus.in_ready); end
    endtask

    task automatic test_4x4_stride1();
        clearStats();
        applyStimulus(4, 4, 1'b0, 1000, 0, 1'b1);
        checks++; if (winCount != 4) begin failures++; $display("[TB] FAIL s1_win_count: got %0d, required 4", winCount); end
        checks++; if (doneCount != 1) begin failures++; $display("[TB] FAIL s1_done_count: got %0d, required 1", doneCount); end
        checks++; if (firstWin !== {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0}) begin
            failures++; $display("[TB] FAIL s1_first_window: got %h, required 0a0908060504020100", firstWin); end
        checks++; if (lastWin !== {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5}) begin
            failures++; $display("[TB] FAIL s1_last_window: got %h, required 0f0e0d0b0a09070605", lastWin); end
        checks++; if (sbQueue.size() != 0) begin failures++; $display("[TB] FAIL s1_missing_windows: got %0d pending, required 0", sbQueue.size()); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL s1_idle_after_done: got in_ready=%b, required 0", bus.in_ready); end
    endtask

    task automatic test_5x5_stride2();
        clearStats();
        applyStimulus(5, 5, 1'b1, 1000, 0, 1'b1);
        checks++; if (winCount != 4) begin failures++; $display("[TB] FAIL s2_5x5_win_count: got %0d, required 4", winCount); end
        checks++; if (doneCount != 1) begin failures++; $display("[TB] FAIL s2_5x5_done_count: got %0d, required 1", doneCount); end
        checks++; if (lastWin !== {8'd24, 8'd23, 8'd22, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12}) begin
            failures++; $display("[TB] FAIL s2_5x5_last_window: got %h, required 1817161312110e0d0c", lastWin); end
        checks++; if (sbQueue.size() != 0) begin failures++; $display("[TB] FAIL s2_5x5_missing_windows: got %0d pending, required 0", sbQueue.size()); end
    endtask

    task automatic test_6x6_stride2();
        clearStats();
        applyStimulus(6, 6, 1'b1, 1000, 0, 1'b1);
        checks++; if (winCount != 4) begin failures++; $display("[TB] FAIL s2_6x6_win_count: got %0d, required 4", winCount); end
        checks++; if (acceptCount != 36) begin failures++; $display("[TB] FAIL s2_6x6_accepts: got %0d, required 36", acceptCount); end
        checks++; if (doneCount != 1) begin failures++; $display("[TB] FAIL s2_6x6_done_count: got %0d, required 1", doneCount); end
        checks++; if (doneCycle - lastAcceptCycle != 2) begin
            failures++; $display("[TB] FAIL s2_6x6_done_latency: got %0d, required 2", doneCycle - lastAcceptCycle); end
    endtask

    task automatic test_backpressure();
        clearStats();
        applyStimulus(4, 4, 1'b0, 1000, 5, 1'b1);
        checks++; if (winCount != 4) begin failures++; $display("[TB] FAIL bp_win_count: got %0d, required 4", winCount); end
        checks++; if (acceptCount != 16) begin failures++; $display("[TB] FAIL bp_accepts: got %0d, required 16", acceptCount); end
        checks++; if (firstWin !== {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0}) begin
            failures++; $display("[TB] FAIL bp_first_window: got %h, required 0a0908060504020100", firstWin); end
        checks++; if (lastWin !== {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5}) begin
            failures++; $display("[TB] FAIL bp_last_window: got %h, required 0f0e0d0b0a09070605", lastWin); end
        checks++; if (doneCount != 1) begin failures++; $display("[TB] FAIL bp_done_count: got %0d, required 1", doneCount); end
    endtask

    task automatic test_abort_restart();
        clearStats();
        applyStimulus(4, 4, 1'b0, 7, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (doneCount != 0) begin failures++; $display("[TB] FAIL abort_early_done: got %0d, required 0", doneCount); end
        applyStimulus(3, 3, 1'b0, 1000, 0, 1'b1);
        checks++; if (winCount != 1) begin failures++; $display("[TB] FAIL abort_win_count: got %0d, required 1", winCount); end
        checks++; if (lastWin !== {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}) begin
            failures++; $display("[TB] FAIL abort_window: got %h, required 080706050403020100", lastWin); end
        checks++; if (doneCount != 1) begin failures++; $display("[TB] FAIL abort_done_count: got %0d, required 1", doneCount); end
    endtask

    task automatic test_reset_midtile();
        int idx;
        int budget;
        clearStats();
        @(posedge clk); #1;
        cfg_tile_in_h = DIM_W'(3);
        cfg_tile_in_w = DIM_W'(3);
        cfg_stride2   = 1'b0;
        start         = 1'b1;
        @(posedge clk); #1;
        start         = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = pix(0, 0, 3);
        idx           = 0;
        budget        = 0;
        while (!bus.out_valid && budget < 100) begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk); #1;
            if (idx < 9) bus.in_data = pix(idx / 3, idx % 3, 3);
            else bus.in_valid = 1'b0;
            budget++;
        end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL midreset_window_pending: got %b, required 1", bus.out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_out_valid: got %b, required 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL midreset_in_ready: got %b, required 0", bus.in_ready); end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        applyStimulus(3, 3, 1'b0, 1000, 0, 1'b1);
        checks++; if (winCount != 1) begin failures++; $display("[TB] FAIL midreset_win_count: got %0d, required 1", winCount); end
        checks++; if (lastWin !== {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}) begin
            failures++; $display("[TB] FAIL midreset_window: got %h, required 080706050403020100", lastWin); end
        checks++; if (doneCount != 1) begin failures++; $display("[TB] FAIL midreset_done_count: got %0d, required 1", doneCount); end
    endtask

    // Test sequence and summary.
    initial begin
        test_reset();
        test_4x4_stride1();
        test_5x5_stride2();
        test_6x6_stride2();
        test_backpressure();
        test_abort_restart();
        test_reset_midtile();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog in case the design stalls the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, required finish within 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/tile_window_gen.md
# tile_window_gen

Streaming 3x3 window generator that sits directly downstream of the tile reader. It consumes the reader's raster-order, zero-padded pixel stream for one input tile and emits one flattened 3x3 window per convolution output position. Stride is 1 or 2. Row history lives in an internal three-row circular line buffer, and the output is a single registered slot with valid/ready backpressure.

## Interface
- `DATA_W`, 8: pixel width.
- `DIM_W`, 16: width of dimension and index fields.
- `MAX_W`, 64: maximum supported tile input width; sets line-buffer depth.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle pulse; latches config and begins a tile.
- `cfg_tile_in_h`  in  DIM_W: input tile height; legal range 3..2^DIM_W-1.
- `cfg_tile_in_w`  in  DIM_W: input tile width; legal range 3..MAX_W.
- `cfg_stride2`  in  1: 0 = stride 1, 1 = stride 2.
- `in_valid`  in  1: input pixel valid.
- `in_ready`  out  1: input pixel accepted when `in_valid && in_ready`.
- `in_data`  in  DATA_W: input pixel.
- `out_valid`  out  1: window valid.
- `out_ready`  in  1: window accepted when `out_valid && out_ready`.
- `out_window`  out  9*DATA_W: slice `[DATA_W*(3*i+j) +: DATA_W]` holds tile pixel (r-2+i, c-2+j), with i, j in 0..2.
- `out_row`  out  DIM_W: output-space row index of the window.
- `out_col`  out  DIM_W: output-space column index of the window.
- `done`  out  1: one-cycle pulse at tile completion.

## Operation
- **Idle.** Block is idle after reset; `in_ready` = 0 while idle.
- **start.** Latches config, clears `r`/`c` counters, clears `out_valid`, becomes active. Applies even mid-tile: that is an abort and restart, and no `done` is issued for the aborted tile.
- **Input acceptance.** While active, `in_ready = !out_valid || out_ready`. Each accepted pixel is at position (r,c) and advances `c`, wrapping at `in_w-1` to 0 with `r++`.
- **Line buffer.** Three rows of MAX_W x DATA_W registers. Pixel (r,c) is written to slot r mod 3 (keep a 0..2 slot counter; no divider).
- **Window shift register.** On each accept, shift a 3-column register left. The new right column is {buf[(r-2) mod 3][c], buf[(r-1) mod 3][c], in_data}, read before the same-cycle write.
- **Emit condition.** A window is emitted for (r,c) when all hold:
  - r >= 2 and c >= 2;
  - for stride 2, additionally (r-2) and (c-2) are even, tracked by phase toggles.
- **Output indices.** `out_row = (r-2)>>s`, `out_col = (c-2)>>s`, where s = stride2.
- **Discarded pixels.** Pixels that do not complete a window are consumed without output: rows 0–1, columns 0–1, and odd phases at stride 2.
- **Tile completion.** The tile is complete when pixel (in_h-1, in_w-1) has been accepted and the output slot is empty.
  - `done` pulses the cycle after that condition first holds.
  - Active then clears and `in_ready` drops.
  - At stride 2 with even dimensions, trailing pixels are consumed and `done` still fires.
- **Arithmetic.** Counters are DIM_W unsigned. `out_h = ((in_h-3)>>s)+1`, and `out_w` likewise.
- **Unsupported config.** `in_w > MAX_W` or dimensions < 3 are unsupported; behaviour is undefined and checked by assertion only.

## Timing
- **Reset values.** `in_ready` = 0, `out_valid` = 0, `out_window` = 0, `out_row` = 0, `out_col` = 0, `done` = 0. Line buffer is not reset.
- **Latency.** `out_valid` rises the cycle after the qualifying pixel's accept edge.
- **Throughput.** One pixel per cycle when `out_ready` is held high.
- **Output stability.** While `out_valid && !out_ready`, `out_window`, `out_row` and `out_col` hold stable and `in_ready` = 0.
- **Simultaneous output accept and input accept.** When an output handshake and an input accept occur in the same cycle that creates a new window, `out_valid` stays 1 and data updates to the new window.
- **start while `out_valid`.** The pending window is dropped.
- **Reset mid-tile.** Returns to idle immediately; `out_valid` clears asynchronously.

## Structure
- **Shared package.** Put the window-index helper constant (`WIN_K = 3`) and the stride encoding in the shared package; the same package also serves the tile reader.
- **Sub-module.** Use one sub-module, `line_buf3`: a 3 x MAX_W register array with one write port and two same-column read ports, selected by row slot.
- **Top level.** Counters, phase logic, shift register and the handshake stay in the top level.

## Test plan
- **4x4 stride 1.** Tile ramp 0..15, stride 1, `out_ready` = 1.
  - Exactly 4 windows, (0,0) (0,1) (1,0) (1,1).
  - First window {0,1,2,4,5,6,8,9,10}; last window {5,6,7,9,10,11,13,14,15}.
  - `done` pulses once.
- **5x5 stride 2.** Ramp 0..24.
  - 4 windows; (0,1) is {2,3,4,7,8,9,12,13,14} and (1,1) is {12,13,14,17,18,19,22,23,24}.
- **6x6 stride 2.** 4 windows; all 36 pixels accepted; `done` pulses the cycle after the 36th accept.
- **Backpressure.** 4x4 stride 1 with `out_ready` low for 5 cycles at the first window.
  - `in_ready` = 0 throughout and the window is held stable.
  - No pixel loss; window sequence identical to the first test.
- **Abort and restart.** Pulse `start` after 7 pixels of a 4x4 tile, then stream a fresh 3x3 ramp 0..8.
  - One window {0..8}; single `done`; no `done` for the aborted tile.
- **Reset mid-tile.** Deassert `rst_n` while `out_valid` = 1.
  - `out_valid` = 0 and `in_ready` = 0 immediately.
  - A subsequent 3x3 tile yields a correct single window.
